// File: rtl/intr_ctrl_if.sv
// Bus bundle between the interrupt controller and its MCU-side master.
// Handshake: the controller raises INTR with a stable INTR_ID; the master
// answers with ACK, which is honoured only on a clock edge where INTR=1.
// INTR then drops for at least two cycles before the next request.
// STATE is a debug view of the controller FSM encoding.
interface intr_ctrl_if #(
  parameter int NUM_CH = 8,
  parameter int ID_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0] IRQ;
  logic              MASK_WE;
  logic [NUM_CH-1:0] MASK_IN;
  logic              ACK;
  logic              INTR;
  logic [ID_W-1:0]   INTR_ID;
  logic [NUM_CH-1:0] PENDING;
  logic [NUM_CH-1:0] MASK;
  logic [1:0]        STATE;

  modport master (
    output IRQ, MASK_WE, MASK_IN, ACK,
    input  INTR, INTR_ID, PENDING, MASK, STATE
  );

  modport slave (
    input  IRQ, MASK_WE, MASK_IN, ACK,
    output INTR, INTR_ID, PENDING, MASK, STATE
  );
endinterface

// File: rtl/intr_ctrl.sv
// Fixed-priority interrupt controller: rising-edge request latching,
// per-channel mask, one request presented at a time to the MCU.
// Optional macro INTR_CTRL_SYNC_EN adds a 2-flop synchronizer on every IRQ
// line ahead of edge detection (two extra cycles of latency).
module intr_ctrl #(
  parameter int NUM_CH = 8,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic        CLK,
  input  logic        RST,
  intr_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_intr;
  logic [ID_W-1:0]   r_intr_id;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_irq_hist;

  logic [NUM_CH-1:0] w_irq_s;
  logic              w_hist_en;
  logic [NUM_CH-1:0] w_edge;
  logic [NUM_CH-1:0] w_ack_clr;
  logic [NUM_CH-1:0] w_req;
  logic [ID_W-1:0]   w_winner;

`ifdef INTR_CTRL_SYNC_EN
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [1:0]        r_sync_vld;

  // Two-stage synchronizer; r_sync_vld marks when r_sync2 carries real
  // line values so the history stays all-ones until then (a line held high
  // through reset is not mistaken for an edge).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sync_vld <= '0;
    end else begin
      r_sync1    <= bus.IRQ;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  assign w_irq_s   = r_sync2;
  assign w_hist_en = r_sync_vld[1];
`else
  assign w_irq_s   = bus.IRQ;
  assign w_hist_en = 1'b1;
`endif

  // Edge-detect history; all-ones at reset so lines already high are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_irq_hist <= '1;
    end else if (w_hist_en) begin
      r_irq_hist <= w_irq_s;
    end
  end

  assign w_edge = w_irq_s & ~r_irq_hist;

  // One-hot clear of the presented channel when the MCU acknowledges in REQ.
  always_comb begin
    w_ack_clr = '0;
    if (r_state == ST_REQ && bus.ACK) begin
      w_ack_clr[r_intr_id] = 1'b1;
    end
  end

  // Pending latches: a new edge wins over a same-cycle acknowledge clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ack_clr) | w_edge;
    end
  end

  // Mask register; all channels disabled out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mask <= '1;
    end else if (bus.MASK_WE) begin
      r_mask <= bus.MASK_IN;
    end
  end

  assign w_req = r_pending & ~r_mask;

  // Fixed priority: lowest index wins, so scan downward and let it overwrite.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_winner = ID_W'(i);
      end
    end
  end

  // Presentation FSM; INTR and INTR_ID are registered here only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_intr    <= 1'b0;
      r_intr_id <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_intr_id <= w_winner;
            r_intr    <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.ACK) begin
            r_intr  <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_intr  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_intr  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.INTR    = r_intr;
  assign bus.INTR_ID = r_intr_id;
  assign bus.PENDING = r_pending;
  assign bus.MASK    = r_mask;
  assign bus.STATE   = r_state;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl (NUM_CH=8). Build with +define+INTR_CTRL_SYNC_EN
// to exercise the synchronized variant; SL adjusts the expected latencies.
module tb_intr_ctrl;

  localparam int NUM_CH = 8;
  localparam int ID_W   = 3;
`ifdef INTR_CTRL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  logic [ID_W-1:0] exp_q[$];

  intr_ctrl_if #(.NUM_CH(NUM_CH), .ID_W(ID_W)) bus ();

  intr_ctrl #(.NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // checking task
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_mask(input logic [NUM_CH-1:0] v);
    bus.MASK_WE = 1'b1;
    bus.MASK_IN = v;
    step();
    bus.MASK_WE = 1'b0;
  endtask

  // One-cycle pulse; returns just after the edge that sets PENDING.
  task automatic irq_pulse(input logic [NUM_CH-1:0] bits);
    bus.IRQ = bits;
    step();
    bus.IRQ = '0;
    repeat (SL) step();
  endtask

  task automatic ack_once();
    bus.ACK = 1'b1;
    step();
    bus.ACK = 1'b0;
  endtask

  // scoreboard: INTR must be high and present the next expected channel
  task automatic present(input string tag);
    logic [ID_W-1:0] e;
    chk({tag, "_intr"}, 32'(bus.INTR), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_id"}, 32'(bus.INTR_ID), 32'(e));
    end
  endtask

  int cnt;

  initial begin
    bus.IRQ     = '0;
    bus.MASK_WE = 1'b0;
    bus.MASK_IN = '0;
    bus.ACK     = 1'b0;
    rst         = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_intr",    32'(bus.INTR),    32'd0);
    chk("rst_id",      32'(bus.INTR_ID), 32'd0);
    chk("rst_pending", 32'(bus.PENDING), 32'h00);
    chk("rst_mask",    32'(bus.MASK),    32'hFF);
    chk("rst_state",   32'(bus.STATE),   32'd0);
    rst = 1'b0;
    repeat (4) step();

    // single channel
    wr_mask(8'h00);
    chk("t1_mask", 32'(bus.MASK), 32'h00);
    irq_pulse(8'h08);
    chk("t1_pend", 32'(bus.PENDING), 32'h08);
    chk("t1_intr_early", 32'(bus.INTR), 32'd0);
    step();
    exp_q.push_back(3'd3);
    present("t1");
    ack_once();
    chk("t1_pend_clr", 32'(bus.PENDING), 32'h00);
    chk("t1_low1", 32'(bus.INTR), 32'd0);
    step();
    chk("t1_low2", 32'(bus.INTR), 32'd0);
    step();

    // priority, plus ACK held through HOLD is ignored
    irq_pulse(8'h22);
    chk("t2_pend", 32'(bus.PENDING), 32'h22);
    step();
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd5);
    present("t2a");
    bus.ACK = 1'b1;
    step();
    chk("t2_pend_a", 32'(bus.PENDING), 32'h20);
    chk("t2_hold_intr", 32'(bus.INTR), 32'd0);
    step();
    bus.ACK = 1'b0;
    chk("t2_hold_ack_ign", 32'(bus.PENDING), 32'h20);
    chk("t2_idle_intr", 32'(bus.INTR), 32'd0);
    step();
    present("t2b");
    ack_once();
    chk("t2_pend_b", 32'(bus.PENDING), 32'h00);
    repeat (2) step();

    // masking, and no withdrawal/replacement while presenting
    wr_mask(8'h04);
    irq_pulse(8'h04);
    chk("t3_pend", 32'(bus.PENDING), 32'h04);
    repeat (2) step();
    chk("t3_masked_intr", 32'(bus.INTR), 32'd0);
    wr_mask(8'h00);
    chk("t3_intr_m0", 32'(bus.INTR), 32'd0);
    step();
    exp_q.push_back(3'd2);
    present("t3a");
    bus.MASK_WE = 1'b1;
    bus.MASK_IN = 8'h04;
    bus.IRQ     = 8'h01;
    step();
    bus.MASK_WE = 1'b0;
    bus.IRQ     = '0;
    repeat (SL) step();
    exp_q.push_back(3'd2);
    present("t3_stable");
    chk("t3_pend2", 32'(bus.PENDING), 32'h05);
    ack_once();
    chk("t3_pend3", 32'(bus.PENDING), 32'h01);
    repeat (2) step();
    exp_q.push_back(3'd0);
    present("t3b");
    ack_once();
    chk("t3_pend4", 32'(bus.PENDING), 32'h00);
    wr_mask(8'h00);
    repeat (2) step();

    // collision: set wins over ACK clear on the same channel
    irq_pulse(8'h08);
    step();
    exp_q.push_back(3'd3);
    present("t4a");
    bus.IRQ = 8'h08;
    repeat (SL) step();
    ack_once();
    bus.IRQ = '0;
    chk("t4_pend_kept", 32'(bus.PENDING), 32'h08);
    chk("t4_low1", 32'(bus.INTR), 32'd0);
    step();
    chk("t4_low2", 32'(bus.INTR), 32'd0);
    step();
    exp_q.push_back(3'd3);
    present("t4b");
    ack_once();
    chk("t4_pend_clr", 32'(bus.PENDING), 32'h00);
    repeat (2) step();

    // asynchronous reset mid-REQ with IRQ[0] held high
    bus.IRQ = 8'h01;
    step();
    repeat (SL) step();
    chk("t5_pend", 32'(bus.PENDING), 32'h01);
    step();
    exp_q.push_back(3'd0);
    present("t5");
    #2 rst = 1'b1;
    #1;
    chk("t5_async_intr", 32'(bus.INTR),    32'd0);
    chk("t5_async_pend", 32'(bus.PENDING), 32'h00);
    chk("t5_async_mask", 32'(bus.MASK),    32'hFF);
    step();
    rst = 1'b0;
    wr_mask(8'h00);
    repeat (4) step();
    chk("t5_no_new_pend", 32'(bus.PENDING), 32'h00);
    chk("t5_no_intr",     32'(bus.INTR),    32'd0);

    // latency from IRQ rise to INTR high (2 cycles, +SL with synchronizer)
    bus.IRQ = '0;
    repeat (3) step();
    bus.IRQ = 8'h01;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt++;
      if (bus.INTR) break;
    end
    bus.IRQ = '0;
    chk("t6_latency", 32'(cnt), 32'(2 + SL));
    exp_q.push_back(3'd0);
    present("t6");
    ack_once();
    chk("t6_pend_clr", 32'(bus.PENDING), 32'h00);
    repeat (2) step();

    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
